// File: rtl/lector_contadores.sv
`default_nettype none
// ============================================================================
//  Module      : lector_contadores
//  Description : Initiator side of the transaction-layer counter-read
//                interface. Keeps a push counter per FIFO, snapshots those
//                counters when a sweep starts, reads back the four pop
//                counters (idx 0..3) over the req/idx -> valid/data
//                handshake, and flags a per-FIFO match or timeout.
//  Revision    : 1.0  initial release
// ============================================================================
module lector_contadores #(
    parameter int CNT_WIDTH = 5,
    parameter int TIMEOUT   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 push_0,
    input  logic                 push_1,
    input  logic                 push_2,
    input  logic                 push_3,
    input  logic                 valid_in,
    input  logic [CNT_WIDTH-1:0] data_in,
    output logic                 req,
    output logic [1:0]           idx,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] count_0,
    output logic [CNT_WIDTH-1:0] count_1,
    output logic [CNT_WIDTH-1:0] count_2,
    output logic [CNT_WIDTH-1:0] count_3,
    output logic [3:0]           match,
    output logic [3:0]           timeout_err
);

    // The wait counter is 8 bits wide, enough for the whole TIMEOUT range.
    // A timeout fires on the TIMEOUT-th WAIT cycle, i.e. when the counter
    // already holds TIMEOUT-1 and valid_in is still low.
    localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_CAPT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t               r_state;
    logic [1:0]           r_idx;
    logic                 r_req;
    logic                 r_busy;
    logic                 r_done;
    logic [7:0]           r_wait;
    logic [3:0]           r_match;
    logic [3:0]           r_terr;
    logic [CNT_WIDTH-1:0] r_push_cnt [4];
    logic [CNT_WIDTH-1:0] r_snap     [4];
    logic [CNT_WIDTH-1:0] r_count    [4];

    logic [3:0]           w_push;

    assign w_push = {push_3, push_2, push_1, push_0};

    // Expected counts: every push strobe is counted in every state, wrapping
    // naturally at the counter width.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_push_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                r_push_cnt[i] <= r_push_cnt[i] + CNT_WIDTH'(w_push[i]);
            end
        end
    end

    // Sweep sequencer: REQ -> WAIT -> CAPT per index, then a one-cycle DONE.
    // req, busy and done are registered alongside the state so they line up
    // exactly with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_idx   <= 2'd0;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_wait  <= 8'd0;
            r_match <= 4'd0;
            r_terr  <= 4'd0;
            for (int i = 0; i < 4; i++) begin
                r_snap[i]  <= '0;
                r_count[i] <= '0;
            end
        end else begin
            r_req  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_REQ;
                        r_idx   <= 2'd0;
                        r_match <= 4'd0;
                        r_terr  <= 4'd0;
                        r_busy  <= 1'b1;
                        r_req   <= 1'b1;
                        // A push landing in the accept cycle belongs to this sweep.
                        for (int i = 0; i < 4; i++) begin
                            r_snap[i] <= r_push_cnt[i] + CNT_WIDTH'(w_push[i]);
                        end
                    end
                end
                S_REQ: begin
                    r_wait  <= 8'd0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A response on the last permitted cycle wins over the timeout.
                    if (valid_in) begin
                        r_count[r_idx] <= data_in;
                        r_state        <= S_CAPT;
                    end else if (r_wait == c_WAIT_LAST) begin
                        r_count[r_idx] <= '0;
                        r_terr[r_idx]  <= 1'b1;
                        r_state        <= S_CAPT;
                    end else begin
                        r_wait <= r_wait + 8'd1;
                    end
                end
                S_CAPT: begin
                    r_match[r_idx] <= (r_count[r_idx] == r_snap[r_idx]) && !r_terr[r_idx];
                    if (r_idx == 2'd3) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx   <= r_idx + 2'd1;
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign req         = r_req;
    assign idx         = r_idx;
    assign busy        = r_busy;
    assign done        = r_done;
    assign count_0     = r_count[0];
    assign count_1     = r_count[1];
    assign count_2     = r_count[2];
    assign count_3     = r_count[3];
    assign match       = r_match;
    assign timeout_err = r_terr;

endmodule
`default_nettype wire
